demux4_reg: RTL and testbench



---
 rtl/demux4_reg_pkg.sv | 12 +
 rtl/demux4_reg_canal.sv | 39 +++
 rtl/demux4_reg.sv | 51 +++++
 tb/tb_demux4_reg.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/demux4_reg_pkg.sv
// Shared constants and channel state encoding for the registered 1x4 demultiplexer.
package demux4_reg_pkg;

  localparam int LARGURA_PADRAO = 32;
  localparam int NUM_CANAIS     = 4;

  typedef enum logic {
    VAZIO = 1'b0,
    CHEIO = 1'b1
  } estado_canal_t;

endpackage

// File: rtl/demux4_reg_canal.sv
// One-entry holding register for a single demux channel: load on carrega, drain on pronta.
module demux_canal
  import demux4_reg_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               carrega,
  input  logic [LARGURA-1:0] dado,
  input  logic               pronta,
  output logic               valida,
  output logic [LARGURA-1:0] saida,
  output logic               cheio
);

  estado_canal_t        r_estado;
  logic [LARGURA-1:0]   r_dado;

  // A load in the same cycle as a drain keeps the channel full with the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado <= VAZIO;
      r_dado   <= '0;
    end else begin
      if (carrega) begin
        r_estado <= CHEIO;
        r_dado   <= dado;
      end else if ((r_estado == CHEIO) && pronta) begin
        r_estado <= VAZIO;
      end
    end
  end

  assign valida = (r_estado == CHEIO);
  assign cheio  = (r_estado == CHEIO);
  assign saida  = r_dado;

endmodule

// File: rtl/demux4_reg.sv
// Registered 1x4 demultiplexer: routes one valid/ready stream to four one-entry channels.
module demux4_reg
  import demux4_reg_pkg::*;
#(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LARGURA-1:0]    entrada,
  input  logic [1:0]            sel,
  input  logic                  entr_valida,
  output logic                  entr_pronta,
  output logic [LARGURA-1:0]    saida0,
  output logic [LARGURA-1:0]    saida1,
  output logic [LARGURA-1:0]    saida2,
  output logic [LARGURA-1:0]    saida3,
  output logic [NUM_CANAIS-1:0] saida_valida,
  input  logic [NUM_CANAIS-1:0] saida_pronta
);

  logic [NUM_CANAIS-1:0] w_cheio;
  logic                  w_aceita;
  logic [LARGURA-1:0]    w_saida [NUM_CANAIS];

  // The target accepts when empty or when its consumer drains it this same cycle.
  assign entr_pronta = !w_cheio[sel] || saida_pronta[sel];
  assign w_aceita    = entr_valida && entr_pronta;

  for (genvar n = 0; n < NUM_CANAIS; n++) begin : g_canal
    localparam logic [1:0] CANAL = 2'(n);

    demux_canal #(
      .LARGURA (LARGURA)
    ) u_canal (
      .clk     (clk),
      .rst_n   (rst_n),
      .carrega (w_aceita && (sel == CANAL)),
      .dado    (entrada),
      .pronta  (saida_pronta[n]),
      .valida  (saida_valida[n]),
      .saida   (w_saida[n]),
      .cheio   (w_cheio[n])
    );
  end

  assign saida0 = w_saida[0];
  assign saida1 = w_saida[1];
  assign saida2 = w_saida[2];
  assign saida3 = w_saida[3];

endmodule

// File: tb/tb_demux4_reg.sv
// Directed and randomized bench for demux4_reg against a per-channel occupancy model.
module tb_demux4_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] entrada;
  logic [1:0]  sel;
  logic        entr_valida;
  logic        entr_pronta;
  logic [31:0] saida0, saida1, saida2, saida3;
  logic [3:0]  saida_valida;
  logic [3:0]  saida_pronta;

  int errors = 0;
  int checks = 0;

  // Reference: each channel either holds a word (mv) with value md, or not.
  logic        mv [4];
  logic [31:0] md [4];

  demux4_reg #(.LARGURA(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entrada      (entrada),
    .sel          (sel),
    .entr_valida  (entr_valida),
    .entr_pronta  (entr_pronta),
    .saida0       (saida0),
    .saida1       (saida1),
    .saida2       (saida2),
    .saida3       (saida3),
    .saida_valida (saida_valida),
    .saida_pronta (saida_pronta)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      mv[n] = 1'b0;
      md[n] = '0;
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] v;
    v = {28'd0, mv[3], mv[2], mv[1], mv[0]};
    check({tag, ".valida"}, {28'd0, saida_valida}, v);
    check({tag, ".saida0"}, saida0, md[0]);
    check({tag, ".saida1"}, saida1, md[1]);
    check({tag, ".saida2"}, saida2, md[2]);
    check({tag, ".saida3"}, saida3, md[3]);
  endtask

  // Drive one cycle at the falling edge, check, then advance the model over the rising edge.
  task automatic cyc(input string tag, input logic ev, input logic [1:0] s,
                     input logic [31:0] d, input logic [3:0] pr);
    logic exp_pronta;
    logic acc;
    @(negedge clk);
    entr_valida  = ev;
    sel          = s;
    entrada      = d;
    saida_pronta = pr;
    #1;
    check_outputs(tag);
    exp_pronta = !mv[s] || pr[s];
    acc        = ev && exp_pronta;
    check({tag, ".entr_pronta"}, {31'd0, entr_pronta}, {31'd0, exp_pronta});
    @(posedge clk);
    for (int n = 0; n < 4; n++) begin
      if (acc && (s == 2'(n))) begin
        mv[n] = 1'b1;
        md[n] = d;
      end else if (mv[n] && pr[n]) begin
        mv[n] = 1'b0;
      end
    end
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    entrada      = '0;
    sel          = 2'd0;
    entr_valida  = 1'b0;
    saida_pronta = 4'd0;
    model_reset();
    #2;
    check("rst.valida", {28'd0, saida_valida}, 32'd0);
    check("rst.entr_pronta", {31'd0, entr_pronta}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset mid-operation
    cyc("fill0", 1'b1, 2'd0, 32'hCAFE0000, 4'b0000);
    cyc("fill2", 1'b1, 2'd2, 32'hCAFE0002, 4'b0000);
    @(negedge clk);
    entr_valida  = 1'b0;
    saida_pronta = 4'b0000;
    #1;
    check("pre_rst.valida", {28'd0, saida_valida}, 32'h5);
    rst_n = 1'b0;
    #1;
    check("mid_rst.valida", {28'd0, saida_valida}, 32'd0);
    check("mid_rst.saida0", saida0, 32'd0);
    check("mid_rst.saida2", saida2, 32'd0);
    check("mid_rst.entr_pronta", {31'd0, entr_pronta}, 32'd1);
    rst_n = 1'b1;
    model_reset();

    // Single transfer
    cyc("single", 1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
    check("single.saida2", saida2, 32'hDEADBEEF);
    check("single.valida", {28'd0, saida_valida}, 32'h4);
    sel = 2'd2;
    #1;
    check("single.pronta_sel2", {31'd0, entr_pronta}, 32'd0);
    sel = 2'd1;
    #1;
    check("single.pronta_sel1", {31'd0, entr_pronta}, 32'd1);

    // Backpressure
    cyc("bp.fill1", 1'b1, 2'd1, 32'h77, 4'b0000);
    cyc("bp.stall", 1'b1, 2'd1, 32'h11, 4'b0000);
    check("bp.held", saida1, 32'h77);
    cyc("bp.release", 1'b1, 2'd1, 32'h11, 4'b0010);
    check("bp.saida1", saida1, 32'h11);
    check("bp.valida1", {31'd0, saida_valida[1]}, 32'd1);

    // Streaming into channel 3
    cyc("drain", 1'b0, 2'd0, 32'd0, 4'b1111);
    for (int k = 1; k <= 4; k++) begin
      cyc($sformatf("stream%0d", k), 1'b1, 2'd3, 32'(k), 4'b1000);
      check($sformatf("stream%0d.saida3", k), saida3, 32'(k));
      check($sformatf("stream%0d.valida3", k), {31'd0, saida_valida[3]}, 32'd1);
    end
    cyc("stream.end", 1'b0, 2'd3, 32'd0, 4'b1000);
    check("stream.valida3_drop", {31'd0, saida_valida[3]}, 32'd0);
    check("stream.saida3_kept", saida3, 32'd4);

    // Parallel drain with simultaneous acceptance
    cyc("par.fill0", 1'b1, 2'd0, 32'hA0, 4'b0000);
    cyc("par.fill1", 1'b1, 2'd1, 32'hA1, 4'b0000);
    cyc("par.fill2", 1'b1, 2'd2, 32'hA2, 4'b0000);
    cyc("par.go", 1'b1, 2'd3, 32'hA5, 4'b0111);
    check("par.valida", {28'd0, saida_valida}, 32'h8);
    check("par.saida3", saida3, 32'hA5);
    check("par.saida0", saida0, 32'hA0);
    check("par.saida1", saida1, 32'hA1);
    check("par.saida2", saida2, 32'hA2);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      cyc($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
          $urandom, 4'($urandom));
    end
    cyc("rnd.final", 1'b0, 2'd0, 32'd0, 4'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
